regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 36 +++
 rtl/regfile_mp.sv | 150 +++++++++++++++
 tb/tb_regfile_mp.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and defaults for the multi-port register file
package regfile_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_XLEN = 32;
    localparam int DEF_XCNT = 32;

    typedef logic [$clog2(DEF_XCNT)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register busy bits; a set in the same cycle as a clear wins
module regfile_scoreboard #(
    parameter  int XCNT = 32,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(XCNT)
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    i_set_en,
    input  logic [AW-1:0]           i_set_idx,
    input  logic [NWR-1:0]          i_clr_en,
    input  logic [NWR-1:0][AW-1:0]  i_clr_idx,
    output logic [XCNT-1:0]         o_busy
);

    logic [XCNT-1:0] r_busy;

    // Set is applied after the clears so it overrides a same-cycle write.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_busy <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (i_clr_en[w]) begin
                    r_busy[i_clr_idx[w]] <= 1'b0;
                end
            end
            if (i_set_en && (i_set_idx != '0)) begin
                r_busy[i_set_idx] <= 1'b1;
            end
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with busy scoreboard; REGFILE_BYPASS_EN enables write-first forwarding
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN = DEF_XLEN,
    parameter  int XCNT = DEF_XCNT,
    parameter  int NRD  = 2,
    parameter  int NWR  = 1,
    localparam int AW   = $clog2(XCNT)
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic [NRD-1:0]           RD_VALID,
    input  logic [NRD-1:0][AW-1:0]   RD_IDX,
    output logic [NRD-1:0]           RD_READY,
    output logic [NRD-1:0]           RD_RESP,
    output logic [NRD-1:0][XLEN-1:0] RD_DATA,
    input  logic [NWR-1:0]           WR_VALID,
    input  logic [NWR-1:0][AW-1:0]   WR_IDX,
    input  logic [NWR-1:0][XLEN-1:0] WR_DATA,
    output logic                     WR_READY,
    input  logic                     SB_SET,
    input  logic [AW-1:0]            SB_IDX,
    output logic [XCNT-1:0]          BUSY
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_run;
    logic [AW-1:0]            r_init_cnt;
    logic [XLEN-1:0]          r_regs [XCNT];
    logic [NRD-1:0]           r_rd_resp;
    logic [NRD-1:0][XLEN-1:0] r_rd_data;
    logic [NRD-1:0][XLEN-1:0] w_rd_val;
    logic [NRD-1:0]           w_rd_hit;
    logic [NRD-1:0]           w_rd_ready;
    logic [NRD-1:0]           w_rd_fire;
    logic [NWR-1:0]           w_wr_fire;
    logic [XCNT-1:0]          w_busy;

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            INIT: begin
                if (r_init_cnt == AW'(XCNT - 1)) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_init_cnt <= '0;
        end else if (r_state == INIT) begin
            r_init_cnt <= r_init_cnt + AW'(1);
        end
    end

    // Writes to index 0 never fire, which keeps x0 hard-wired to zero.
    always_comb begin
        w_wr_fire = '0;
        for (int w = 0; w < NWR; w++) begin
            w_wr_fire[w] = WR_VALID[w] && w_run && (WR_IDX[w] != '0);
        end
    end

    // Storage has no reset; INIT sweeps every entry to zero instead.
    always_ff @(posedge CLK) begin
        if (r_state == INIT) begin
            r_regs[r_init_cnt] <= '0;
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (w_wr_fire[w]) begin
                    r_regs[WR_IDX[w]] <= WR_DATA[w];
                end
            end
        end
    end

    always_comb begin
        w_rd_val   = '0;
        w_rd_hit   = '0;
        w_rd_ready = '0;
        w_rd_fire  = '0;
        for (int c = 0; c < NRD; c++) begin
            w_rd_val[c] = (RD_IDX[c] == '0) ? '0 : r_regs[RD_IDX[c]];
`ifdef REGFILE_BYPASS_EN
            // Later write channels override earlier ones, matching storage precedence.
            for (int w = 0; w < NWR; w++) begin
                if (w_wr_fire[w] && (WR_IDX[w] == RD_IDX[c])) begin
                    w_rd_val[c] = WR_DATA[w];
                    w_rd_hit[c] = 1'b1;
                end
            end
`endif
            w_rd_ready[c] = w_run && ((RD_IDX[c] == '0) || !w_busy[RD_IDX[c]] || w_rd_hit[c]);
            w_rd_fire[c]  = RD_VALID[c] && w_rd_ready[c];
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_rd_resp <= '0;
            r_rd_data <= '0;
        end else begin
            r_rd_resp <= w_rd_fire;
            for (int c = 0; c < NRD; c++) begin
                if (w_rd_fire[c]) begin
                    r_rd_data[c] <= w_rd_val[c];
                end
            end
        end
    end

    regfile_scoreboard #(
        .XCNT (XCNT),
        .NWR  (NWR)
    ) u_scoreboard (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .i_set_en  (SB_SET && w_run),
        .i_set_idx (SB_IDX),
        .i_clr_en  (w_wr_fire),
        .i_clr_idx (WR_IDX),
        .o_busy    (w_busy)
    );

    assign RD_READY = w_rd_ready;
    assign WR_READY = w_run;
    assign RD_RESP  = r_rd_resp;
    assign RD_DATA  = r_rd_data;
    assign BUSY     = w_busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (NRD=2, NWR=2) against a behavioural model
module tb_regfile_mp;
    import regfile_pkg::*;

    logic              CLK;
    logic              RSTN;
    logic [1:0]        RD_VALID;
    logic [1:0][4:0]   RD_IDX;
    logic [1:0]        RD_READY;
    logic [1:0]        RD_RESP;
    logic [1:0][31:0]  RD_DATA;
    logic [1:0]        WR_VALID;
    logic [1:0][4:0]   WR_IDX;
    logic [1:0][31:0]  WR_DATA;
    logic              WR_READY;
    logic              SB_SET;
    reg_idx_t          SB_IDX;
    logic [31:0]       BUSY;

    int checks = 0;
    int errors = 0;

    logic [31:0]       m_regs [32];
    logic [31:0]       m_busy;
    bit                m_run = 0;
    int                m_init = 0;
    logic [1:0]        e_rd_ready;
    logic              e_wr_ready;
    logic [1:0]        e_resp;
    logic [1:0][31:0]  e_data;
    logic [1:0]        o_rd_ready;
    logic              o_wr_ready;

    regfile_mp #(
        .XLEN (32),
        .XCNT (32),
        .NRD  (2),
        .NWR  (2)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .RD_VALID (RD_VALID),
        .RD_IDX   (RD_IDX),
        .RD_READY (RD_READY),
        .RD_RESP  (RD_RESP),
        .RD_DATA  (RD_DATA),
        .WR_VALID (WR_VALID),
        .WR_IDX   (WR_IDX),
        .WR_DATA  (WR_DATA),
        .WR_READY (WR_READY),
        .SB_SET   (SB_SET),
        .SB_IDX   (SB_IDX),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        RD_VALID = '0;
        RD_IDX   = '0;
        WR_VALID = '0;
        WR_IDX   = '0;
        WR_DATA  = '0;
        SB_SET   = 1'b0;
        SB_IDX   = '0;
    endtask

    // One clock: predict from the model, sample ready outputs, advance, then update the model.
    task automatic tick();
        logic [31:0] val [2];
        logic        hit;
        #1;
        for (int c = 0; c < 2; c++) begin
            val[c] = (RD_IDX[c] == 0) ? 32'd0 : m_regs[RD_IDX[c]];
            hit = 1'b0;
`ifdef REGFILE_BYPASS_EN
            for (int w = 0; w < 2; w++) begin
                if (WR_VALID[w] && WR_IDX[w] == RD_IDX[c] && RD_IDX[c] != 0) begin
                    val[c] = WR_DATA[w];
                    hit = 1'b1;
                end
            end
`endif
            e_rd_ready[c] = m_run && (RD_IDX[c] == 0 || !m_busy[RD_IDX[c]] || hit);
        end
        e_wr_ready = m_run;
        o_rd_ready = RD_READY;
        o_wr_ready = WR_READY;
        @(posedge CLK);
        #1;
        if (!RSTN) begin
            m_run  = 0;
            m_init = 0;
            m_busy = '0;
            e_resp = '0;
            e_data = '0;
        end else if (!m_run) begin
            e_resp = '0;
            m_init++;
            if (m_init == 32) begin
                m_run = 1;
                for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                e_resp[c] = RD_VALID[c] && e_rd_ready[c];
                if (e_resp[c]) e_data[c] = val[c];
            end
            for (int w = 0; w < 2; w++) begin
                if (WR_VALID[w] && WR_IDX[w] != 0) begin
                    m_regs[WR_IDX[w]] = WR_DATA[w];
                    m_busy[WR_IDX[w]] = 1'b0;
                end
            end
            if (SB_SET && SB_IDX != 0) m_busy[SB_IDX] = 1'b1;
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        idle();
        tick();
        tick();
        checks++; if (RD_RESP !== 2'b00) begin errors++; $display("FAIL rst_resp got %b exp 00", RD_RESP); end
        checks++; if (RD_DATA !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", RD_DATA); end
        checks++; if (BUSY !== 32'd0) begin errors++; $display("FAIL rst_busy got %h exp 0", BUSY); end
        RSTN = 1'b1;
        RD_VALID = 2'b11; RD_IDX[0] = 5'd5;
        WR_VALID = 2'b01; WR_IDX[0] = 5'd6; WR_DATA[0] = 32'hABCD;
        SB_SET = 1'b1; SB_IDX = 5'd8;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++;
            if (o_rd_ready !== 2'b00 || o_wr_ready !== 1'b0 || RD_RESP !== 2'b00) begin
                errors++;
                $display("FAIL init_ready cycle %0d got rd_ready=%b wr_ready=%b resp=%b exp 0/0/0", i, o_rd_ready, o_wr_ready, RD_RESP);
            end
        end
        idle();
        RD_VALID = 2'b01; RD_IDX[0] = 5'd5;
        tick();
        checks++; if (o_wr_ready !== 1'b1 || o_rd_ready[0] !== 1'b1) begin errors++; $display("FAIL run_ready got wr=%b rd=%b exp 1/1", o_wr_ready, o_rd_ready[0]); end
        checks++; if (RD_RESP[0] !== 1'b1 || RD_DATA[0] !== 32'd0) begin errors++; $display("FAIL read_x5 got resp=%b data=%h exp 1/0", RD_RESP[0], RD_DATA[0]); end
        checks++; if (BUSY !== 32'd0) begin errors++; $display("FAIL init_sbset got busy=%h exp 0", BUSY); end
    endtask

    task automatic test_write_read();
        idle();
        WR_VALID = 2'b01; WR_IDX[0] = 5'd3; WR_DATA[0] = 32'hDEADBEEF;
        tick();
        idle();
        RD_VALID = 2'b01; RD_IDX[0] = 5'd3;
        tick();
        checks++; if (RD_RESP[0] !== 1'b1 || RD_DATA[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_x3 got resp=%b data=%h exp 1/deadbeef", RD_RESP[0], RD_DATA[0]); end
        idle();
        WR_VALID = 2'b01; WR_IDX[0] = 5'd0; WR_DATA[0] = 32'h1;
        tick();
        idle();
        RD_VALID = 2'b11; RD_IDX[0] = 5'd0; RD_IDX[1] = 5'd0;
        tick();
        checks++; if (RD_RESP !== 2'b11 || RD_DATA[0] !== 32'd0 || RD_DATA[1] !== 32'd0) begin errors++; $display("FAIL wr_rd_x0 got resp=%b data=%h exp 11/0", RD_RESP, RD_DATA); end
        idle();
        tick();
        checks++; if (RD_RESP !== 2'b00 || RD_DATA[0] !== 32'd0) begin errors++; $display("FAIL hold_data got resp=%b data=%h exp 00/0", RD_RESP, RD_DATA[0]); end
    endtask

    task automatic test_scoreboard();
        idle();
        SB_SET = 1'b1; SB_IDX = 5'd7;
        tick();
        checks++; if (BUSY[7] !== 1'b1) begin errors++; $display("FAIL sb_set_x7 got %b exp 1", BUSY[7]); end
        idle();
        RD_VALID = 2'b01; RD_IDX[0] = 5'd7;
        tick();
        checks++; if (o_rd_ready[0] !== 1'b0 || RD_RESP[0] !== 1'b0) begin errors++; $display("FAIL sb_block got ready=%b resp=%b exp 0/0", o_rd_ready[0], RD_RESP[0]); end
        WR_VALID = 2'b10; WR_IDX[1] = 5'd7; WR_DATA[1] = 32'h55;
        tick();
        checks++; if (o_rd_ready[0] !== e_rd_ready[0]) begin errors++; $display("FAIL sb_wr_ready got %b exp %b", o_rd_ready[0], e_rd_ready[0]); end
        checks++; if (BUSY[7] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b exp 0", BUSY[7]); end
        WR_VALID = 2'b00;
        tick();
        checks++; if (o_rd_ready[0] !== 1'b1 || RD_RESP[0] !== 1'b1 || RD_DATA[0] !== 32'h55) begin errors++; $display("FAIL sb_read got ready=%b resp=%b data=%h exp 1/1/55", o_rd_ready[0], RD_RESP[0], RD_DATA[0]); end
    endtask

    task automatic test_collision();
        idle();
        WR_VALID = 2'b11; WR_IDX[0] = 5'd9; WR_IDX[1] = 5'd9; WR_DATA[0] = 32'h1; WR_DATA[1] = 32'h2;
        tick();
        idle();
        RD_VALID = 2'b10; RD_IDX[1] = 5'd9;
        tick();
        checks++; if (RD_RESP[1] !== 1'b1 || RD_DATA[1] !== 32'h2) begin errors++; $display("FAIL wr_collide got resp=%b data=%h exp 1/2", RD_RESP[1], RD_DATA[1]); end
        idle();
        SB_SET = 1'b1; SB_IDX = 5'd9;
        WR_VALID = 2'b01; WR_IDX[0] = 5'd9; WR_DATA[0] = 32'h33;
        tick();
        checks++; if (BUSY[9] !== 1'b1) begin errors++; $display("FAIL set_wins got %b exp 1", BUSY[9]); end
        idle();
        RD_VALID = 2'b01; RD_IDX[0] = 5'd9;
        tick();
        checks++; if (o_rd_ready[0] !== 1'b0) begin errors++; $display("FAIL set_wins_ready got %b exp 0", o_rd_ready[0]); end
        idle();
        WR_VALID = 2'b01; WR_IDX[0] = 5'd9; WR_DATA[0] = 32'h34;
        tick();
        checks++; if (BUSY[9] !== 1'b0) begin errors++; $display("FAIL busy_write got %b exp 0", BUSY[9]); end
    endtask

    task automatic test_bypass();
        logic [31:0] exp_val;
`ifdef REGFILE_BYPASS_EN
        exp_val = 32'h20;
`else
        exp_val = 32'h10;
`endif
        idle();
        WR_VALID = 2'b01; WR_IDX[0] = 5'd4; WR_DATA[0] = 32'h10;
        tick();
        idle();
        WR_VALID = 2'b01; WR_IDX[0] = 5'd4; WR_DATA[0] = 32'h20;
        RD_VALID = 2'b11; RD_IDX[0] = 5'd4; RD_IDX[1] = 5'd4;
        tick();
        checks++; if (RD_RESP !== 2'b11 || RD_DATA[0] !== exp_val || RD_DATA[1] !== exp_val) begin errors++; $display("FAIL bypass got resp=%b data=%h exp 11/%h", RD_RESP, RD_DATA, exp_val); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            idle();
            RD_VALID = 2'($urandom);
            WR_VALID = 2'($urandom);
            for (int c = 0; c < 2; c++) begin
                RD_IDX[c]  = 5'($urandom_range(0, 7));
                WR_IDX[c]  = 5'($urandom_range(0, 7));
                WR_DATA[c] = $urandom;
            end
            SB_SET = ($urandom_range(0, 4) == 0);
            SB_IDX = 5'($urandom_range(0, 7));
            tick();
            checks++; if (o_rd_ready !== e_rd_ready || o_wr_ready !== e_wr_ready) begin errors++; $display("FAIL rnd_ready n=%0d got %b/%b exp %b/%b", n, o_rd_ready, o_wr_ready, e_rd_ready, e_wr_ready); end
            checks++; if (RD_RESP !== e_resp) begin errors++; $display("FAIL rnd_resp n=%0d got %b exp %b", n, RD_RESP, e_resp); end
            checks++; if (RD_DATA !== e_data) begin errors++; $display("FAIL rnd_data n=%0d got %h exp %h", n, RD_DATA, e_data); end
            checks++; if (BUSY !== m_busy) begin errors++; $display("FAIL rnd_busy n=%0d got %h exp %h", n, BUSY, m_busy); end
        end
    endtask

    task automatic test_reset_midrun();
        idle();
        SB_SET = 1'b1; SB_IDX = 5'd12;
        WR_VALID = 2'b01; WR_IDX[0] = 5'd3; WR_DATA[0] = 32'hCAFE0003;
        tick();
        idle();
        RD_VALID = 2'b01; RD_IDX[0] = 5'd3;
        RSTN = 1'b0;
        tick();
        checks++; if (RD_RESP !== 2'b00 || RD_DATA !== '0 || BUSY !== 32'd0) begin errors++; $display("FAIL midrun_rst got resp=%b data=%h busy=%h exp 0/0/0", RD_RESP, RD_DATA, BUSY); end
        RSTN = 1'b1;
        RD_VALID = 2'b11; RD_IDX[1] = 5'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            checks++; if (o_rd_ready !== 2'b00 || RD_RESP !== 2'b00) begin errors++; $display("FAIL reinit cycle %0d got rd_ready=%b resp=%b exp 00/00", i, o_rd_ready, RD_RESP); end
        end
        for (int i = 1; i < 32; i += 2) begin
            idle();
            RD_VALID = 2'b11; RD_IDX[0] = 5'(i); RD_IDX[1] = 5'(i + 1);
            tick();
            checks++; if (RD_RESP !== 2'b11 || RD_DATA !== '0) begin errors++; $display("FAIL reinit_zero idx %0d got resp=%b data=%h exp 11/0", i, RD_RESP, RD_DATA); end
        end
    endtask

    initial begin
        RSTN = 1'b0;
        idle();
        m_busy = '0;
        e_resp = '0;
        e_data = '0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_random();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
